wb_request_arbiter: RTL and testbench

WB_REQUEST_ARBITER -- requirements
Module: wb_request_arbiter

---
 rtl/wb_request_arbiter.sv | 155 +++++++++++++++
 tb/tb_wb_request_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_request_arbiter.sv
// rtl/wb_request_arbiter.sv - two-requester round-robin arbiter onto a single-beat Wishbone master
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   req_request[1:0]     per-requester request
//   req_addr/req_data    64-bit packed, requester i in [32i+31:32i]
//   req_rnw[1:0]         1 = read, 0 = write
//   req_be[7:0]          byte enables, requester i in [4i+3:4i]
//   req_ack[1:0]         combinational accept pulse in the granting IDLE cycle
//   rsp_data/valid/err   registered completion towards the owning requester
//   wb_*                 Wishbone classic single-cycle master interface
module wb_request_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_request,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_data,
    input  logic [1:0]  req_rnw,
    input  logic [7:0]  req_be,
    output logic [1:0]  req_ack,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_valid,
    output logic        rsp_err,
    output logic [29:0] wb_adr,
    output logic [31:0] wb_dat_w,
    output logic [3:0]  wb_sel,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [2:0]  wb_cti,
    output logic [1:0]  wb_bte,
    input  logic [31:0] wb_dat_r,
    input  logic        wb_ack,
    input  logic        wb_err
);

    typedef enum logic {IDLE, BUS} state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES[7:0];

    state_t      state;
    state_t      state_next;
    logic        last_grant;
    logic        owner;
    logic [7:0]  tcount;

    logic        grant_valid;
    logic        grant_idx;
    logic [31:0] sel_addr;
    logic [31:0] sel_data;
    logic        sel_rnw;
    logic [3:0]  sel_be;
    logic        timeout_hit;
    logic        term;
    logic        term_err;

    // Byte-offset bits never reach the word-addressed bus.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[33:32], req_addr[1:0]};

    // A tie goes to whoever was not granted last; otherwise the lone requester wins.
    always_comb begin
        grant_valid = |req_request;
        if (req_request == 2'b11) begin
            grant_idx = ~last_grant;
        end else begin
            grant_idx = req_request[1];
        end
    end

    assign sel_addr = grant_idx ? req_addr[63:32] : req_addr[31:0];
    assign sel_data = grant_idx ? req_data[63:32] : req_data[31:0];
    assign sel_rnw  = grant_idx ? req_rnw[1]      : req_rnw[0];
    assign sel_be   = grant_idx ? req_be[7:4]     : req_be[3:0];

    assign timeout_hit = (TIMEOUT_LIMIT != 8'd0) && (tcount == TIMEOUT_LIMIT);

    always_comb begin
        state_next = state;
        req_ack    = 2'b00;
        term       = 1'b0;
        term_err   = 1'b0;
        case (state)
            IDLE: begin
                if (!rst && grant_valid) begin
                    req_ack    = grant_idx ? 2'b10 : 2'b01;
                    state_next = BUS;
                end
            end
            BUS: begin
                // Slave termination beats the timeout; error beats ack.
                if (wb_err) begin
                    term     = 1'b1;
                    term_err = 1'b1;
                end else if (wb_ack) begin
                    term     = 1'b1;
                end else if (timeout_hit) begin
                    term     = 1'b1;
                    term_err = 1'b1;
                end
                if (term) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            tcount     <= 8'd0;
            wb_adr     <= 30'd0;
            wb_dat_w   <= 32'd0;
            wb_sel     <= 4'd0;
            wb_we      <= 1'b0;
            rsp_valid  <= 2'b00;
            rsp_err    <= 1'b0;
            rsp_data   <= 32'd0;
        end else begin
            state     <= state_next;
            rsp_valid <= 2'b00;
            rsp_err   <= 1'b0;
            if (state == IDLE) begin
                if (grant_valid) begin
                    owner      <= grant_idx;
                    last_grant <= grant_idx;
                    tcount     <= 8'd0;
                    wb_adr     <= sel_addr[31:2];
                    wb_dat_w   <= sel_data;
                    wb_we      <= ~sel_rnw;
                    wb_sel     <= sel_rnw ? 4'hF : sel_be;
                end
            end else begin
                if (term) begin
                    rsp_valid <= owner ? 2'b10 : 2'b01;
                    rsp_err   <= term_err;
                    rsp_data  <= (!term_err && !wb_we) ? wb_dat_r : 32'd0;
                end else begin
                    tcount <= tcount + 8'd1;
                end
            end
        end
    end

    assign wb_cyc = (state == BUS);
    assign wb_stb = (state == BUS);
    assign wb_cti = 3'b000;
    assign wb_bte = 2'b00;

endmodule

// File: tb/tb_wb_request_arbiter.sv
// tb/tb_wb_request_arbiter.sv - directed self-checking bench for wb_request_arbiter
module tb_wb_request_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_request;
    logic [63:0] req_addr;
    logic [63:0] req_data;
    logic [1:0]  req_rnw;
    logic [7:0]  req_be;
    logic [1:0]  req_ack;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_valid;
    logic        rsp_err;
    logic [29:0] wb_adr;
    logic [31:0] wb_dat_w;
    logic [3:0]  wb_sel;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;
    logic [31:0] wb_dat_r;
    logic        wb_ack;
    logic        wb_err;

    int compared = 0;
    int mismatched = 0;

    wb_request_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .req_request(req_request), .req_addr(req_addr), .req_data(req_data),
        .req_rnw(req_rnw), .req_be(req_be), .req_ack(req_ack),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_sel(wb_sel),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
        .wb_cti(wb_cti), .wb_bte(wb_bte),
        .wb_dat_r(wb_dat_r), .wb_ack(wb_ack), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        int r1_grant_at;
        logic r1_pend;
        logic [1:0] g;
        logic [1:0] prev_g;

        rst = 1'b1;
        req_request = 2'b11;
        req_addr = {32'h0000_2000, 32'h0000_1000};
        req_data = 64'd0;
        req_rnw = 2'b11;
        req_be = 8'hFF;
        wb_dat_r = 32'd0;
        wb_ack = 1'b0;
        wb_err = 1'b0;
        tick();
        tick();

        // Reset state, with both requests up while rst is high
        chk("rst_req_ack", req_ack, 2'b00);
        chk("rst_wb_cyc", wb_cyc, 1'b0);
        chk("rst_wb_stb", wb_stb, 1'b0);
        chk("rst_wb_we", wb_we, 1'b0);
        chk("rst_wb_adr", wb_adr, 30'd0);
        chk("rst_wb_sel", wb_sel, 4'd0);
        chk("rst_wb_dat_w", wb_dat_w, 32'd0);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("wb_cti", wb_cti, 3'b000);
        chk("wb_bte", wb_bte, 2'b00);

        // Tie after reset: requester 0 first, then requester 1
        rst = 1'b0;
        #1;
        chk("t1_req_ack0", req_ack, 2'b01);
        tick();
        req_request = 2'b10;
        chk("t1_cyc", wb_cyc, 1'b1);
        chk("t1_stb", wb_stb, 1'b1);
        chk("t1_adr0", wb_adr, 30'h400);
        chk("t1_we", wb_we, 1'b0);
        chk("t1_sel", wb_sel, 4'hF);
        chk("t1_ack_in_bus", req_ack, 2'b00);
        wb_ack = 1'b1;
        wb_dat_r = 32'hDEAD_BEEF;
        tick();
        wb_ack = 1'b0;
        chk("t1_rsp_valid0", rsp_valid, 2'b01);
        chk("t1_rsp_data0", rsp_data, 32'hDEAD_BEEF);
        chk("t1_rsp_err0", rsp_err, 1'b0);
        chk("t1_cyc_low", wb_cyc, 1'b0);
        chk("t1_req_ack1", req_ack, 2'b10);
        tick();
        req_request = 2'b00;
        chk("t1_adr1", wb_adr, 30'h800);
        wb_ack = 1'b1;
        wb_dat_r = 32'h1234_5678;
        tick();
        wb_ack = 1'b0;
        chk("t1_rsp_valid1", rsp_valid, 2'b10);
        chk("t1_rsp_data1", rsp_data, 32'h1234_5678);

        // Requester 1 write with partial byte enables, one wait state
        req_request = 2'b10;
        req_rnw = 2'b00;
        req_addr = {32'h0000_0010, 32'h0000_0000};
        req_data = {32'hA5A5_A5A5, 32'h0000_0000};
        req_be = 8'b0011_0000;
        #1;
        chk("t2_req_ack", req_ack, 2'b10);
        tick();
        req_request = 2'b00;
        chk("t2_we", wb_we, 1'b1);
        chk("t2_sel", wb_sel, 4'b0011);
        chk("t2_adr", wb_adr, 30'h4);
        chk("t2_dat_w", wb_dat_w, 32'hA5A5_A5A5);
        tick();
        chk("t2_wait_cyc", wb_cyc, 1'b1);
        chk("t2_wait_valid", rsp_valid, 2'b00);
        wb_ack = 1'b1;
        wb_dat_r = 32'hFFFF_FFFF;
        tick();
        wb_ack = 1'b0;
        chk("t2_rsp_valid", rsp_valid, 2'b10);
        chk("t2_rsp_err", rsp_err, 1'b0);
        chk("t2_rsp_data", rsp_data, 32'd0);

        // Bus error on a read, with ack also high: error wins
        req_request = 2'b01;
        req_rnw = 2'b11;
        req_addr = {32'h0, 32'h0000_0100};
        tick();
        req_request = 2'b00;
        wb_err = 1'b1;
        wb_ack = 1'b1;
        wb_dat_r = 32'h0000_0123;
        tick();
        wb_err = 1'b0;
        wb_ack = 1'b0;
        chk("t3_rsp_valid", rsp_valid, 2'b01);
        chk("t3_rsp_err", rsp_err, 1'b1);
        chk("t3_rsp_data", rsp_data, 32'd0);
        chk("t3_cyc_low", wb_cyc, 1'b0);

        // Silent slave: timeout after 5 bus cycles
        req_request = 2'b01;
        tick();
        req_request = 2'b00;
        n = 0;
        while (wb_cyc && n < 20) begin
            n++;
            tick();
        end
        chk("t4_cyc_cycles", n, 5);
        chk("t4_rsp_valid", rsp_valid, 2'b01);
        chk("t4_rsp_err", rsp_err, 1'b1);

        // Ack on the timeout cycle wins over the timeout
        req_request = 2'b01;
        tick();
        req_request = 2'b00;
        repeat (4) tick();
        chk("t4b_still_bus", wb_cyc, 1'b1);
        wb_ack = 1'b1;
        wb_dat_r = 32'h5555_AAAA;
        tick();
        wb_ack = 1'b0;
        chk("t4b_rsp_valid", rsp_valid, 2'b01);
        chk("t4b_rsp_err", rsp_err, 1'b0);
        chk("t4b_rsp_data", rsp_data, 32'h5555_AAAA);

        // Reset mid-bus, late ack afterwards
        req_request = 2'b01;
        tick();
        req_request = 2'b00;
        tick();
        chk("t5_in_bus", wb_cyc, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_cyc_after_rst", wb_cyc, 1'b0);
        chk("t5_valid_after_rst", rsp_valid, 2'b00);
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        chk("t5_late_ack_valid", rsp_valid, 2'b00);
        chk("t5_late_ack_cyc", wb_cyc, 1'b0);
        tick();
        chk("t5_late_ack_valid2", rsp_valid, 2'b00);

        // Fairness: requester 0 always requesting, requester 1 once at transaction 5
        r1_pend = 1'b0;
        r1_grant_at = -1;
        prev_g = 2'b00;
        req_rnw = 2'b11;
        for (int t = 0; t < 21; t++) begin
            if (t == 5) r1_pend = 1'b1;
            req_request = {r1_pend, 1'b1};
            #1;
            g = req_ack;
            if (t > 0) chk("t6_back_to_back_valid", rsp_valid, prev_g);
            if (g == 2'b10) begin
                r1_pend = 1'b0;
                r1_grant_at = t;
            end else begin
                chk("t6_grant_r0", g, 2'b01);
            end
            prev_g = g;
            tick();
            req_request = 2'b01;
            wb_ack = 1'b1;
            tick();
            wb_ack = 1'b0;
        end
        chk("t6_r1_granted_at", r1_grant_at, 5);
        chk("t6_final_valid", rsp_valid, prev_g);
        req_request = 2'b00;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
